// File: rtl/skinny_round_ctrl.sv
// Round sequencer for the iterative Skinny-128-384 datapath: load, NUM_ROUNDS
// round enables with index and LFSR round constant, then a valid/ready handoff.
module skinny_round_ctrl #(
  parameter int NUM_ROUNDS = 56,
  parameter int CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             stall,
  input  logic             ready,
  output logic             busy,
  output logic             load,
  output logic             round_en,
  output logic [CNT_W-1:0] round_idx,
  output logic [5:0]       rc,
  output logic             last_round,
  output logic             valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS - 1);
  localparam logic [CNT_W-1:0] IDX_ZERO = {CNT_W{1'b0}};
  localparam logic [5:0]       RC_INIT  = 6'h01;

  // Skinny 6-bit round-constant LFSR step
  function automatic logic [5:0] rc_step(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4] ^ 1'b1};
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] idx_r;
  logic [CNT_W-1:0] idx_nxt_s;
  logic [5:0]       rc_r;
  logic [5:0]       rc_nxt_s;
  logic             busy_r;
  logic             load_r;
  logic             last_r;
  logic             valid_r;
  logic             busy_nxt_s;
  logic             load_nxt_s;
  logic             last_nxt_s;
  logic             valid_nxt_s;
  logic             at_last_s;

  assign at_last_s = (idx_r == LAST_IDX);

  // State, counters and registered output flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      idx_r   <= IDX_ZERO;
      rc_r    <= RC_INIT;
      busy_r  <= 1'b0;
      load_r  <= 1'b0;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      rc_r    <= rc_nxt_s;
      busy_r  <= busy_nxt_s;
      load_r  <= load_nxt_s;
      last_r  <= last_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Next-state decode; abort returns to IDLE from any state
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: state_nxt_s = ST_ROUND;
        ST_ROUND: begin
          if (at_last_s && !stall) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ROUND;
          end
        end
        ST_DONE: begin
          if (ready) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output decode: counters advance only while staying in ROUND unstalled,
  // and fall back to their initial values whenever ROUND is not continuing
  always_comb begin
    idx_nxt_s = IDX_ZERO;
    rc_nxt_s  = RC_INIT;
    if ((state_r == ST_ROUND) && (state_nxt_s == ST_ROUND)) begin
      if (stall) begin
        idx_nxt_s = idx_r;
        rc_nxt_s  = rc_r;
      end else begin
        idx_nxt_s = idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
        rc_nxt_s  = rc_step(rc_r);
      end
    end else begin
      idx_nxt_s = IDX_ZERO;
      rc_nxt_s  = RC_INIT;
    end
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    load_nxt_s  = (state_nxt_s == ST_LOAD);
    valid_nxt_s = (state_nxt_s == ST_DONE);
    last_nxt_s  = (state_nxt_s == ST_ROUND) && (idx_nxt_s == LAST_IDX);
  end

  assign round_en   = (state_r == ST_ROUND) & ~stall;
  assign busy       = busy_r;
  assign load       = load_r;
  assign round_idx  = idx_r;
  assign rc         = rc_r;
  assign last_round = last_r;
  assign valid      = valid_r;

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Bench for skinny_round_ctrl: a job-level model (rounds-done count per job)
// checked every cycle against two instances (56 rounds and 1 round).
module tb_skinny_round_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic stall = 1'b0;
  logic ready = 1'b1;

  logic       busy0, load0, ren0, last0, valid0;
  logic [5:0] idx0, rc0;
  logic       busy1, load1, ren1, last1, valid1;
  logic [0:0] idx1;
  logic [5:0] rc1;

  always #5 clock = ~clock;

  skinny_round_ctrl #(.NUM_ROUNDS(56), .CNT_W(6)) dut0 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .stall(stall), .ready(ready),
    .busy(busy0), .load(load0), .round_en(ren0), .round_idx(idx0), .rc(rc0),
    .last_round(last0), .valid(valid0)
  );

  skinny_round_ctrl #(.NUM_ROUNDS(1), .CNT_W(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .stall(stall), .ready(ready),
    .busy(busy1), .load(load1), .round_en(ren1), .round_idx(idx1), .rc(rc1),
    .last_round(last1), .valid(valid1)
  );

  int  n_pass  = 0;
  int  n_total = 0;
  bit  cmp_en  = 1'b0;

  // model: per instance, is a job active and how many rounds it has applied
  // (-1 while loading, NUM_ROUNDS once waiting for ready)
  logic [5:0] rc_tab [0:63];
  int  m_n [2] = '{56, 1};
  bit  m_busy [2] = '{1'b0, 1'b0};
  int  m_r [2] = '{0, 0};

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // {busy, load, round_en, idx[5:0], rc[5:0], last_round, valid}
  function automatic logic [16:0] expect_vec(input int k);
    logic in_round;
    int   idx;
    in_round = m_busy[k] && (m_r[k] >= 0) && (m_r[k] < m_n[k]);
    idx      = in_round ? m_r[k] : 0;
    return {m_busy[k], m_busy[k] && (m_r[k] == -1), in_round && !stall, 6'(idx),
            in_round ? rc_tab[idx] : 6'h01, in_round && (m_r[k] == m_n[k] - 1),
            m_busy[k] && (m_r[k] == m_n[k])};
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_busy[k] <= 1'b0;
        m_r[k]    <= 0;
      end else if (abort) begin
        m_busy[k] <= 1'b0;
      end else if (!m_busy[k]) begin
        if (start) begin
          m_busy[k] <= 1'b1;
          m_r[k]    <= -1;
        end
      end else if (m_r[k] < m_n[k]) begin
        if (m_r[k] == -1 || !stall) m_r[k] <= m_r[k] + 1;
      end else if (ready) begin
        m_busy[k] <= 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("dut0 outputs", int'({busy0, load0, ren0, idx0, rc0, last0, valid0}), int'(expect_vec(0)));
      check("dut1 outputs", int'({busy1, load1, ren1, 5'b0, idx1, rc1, last1, valid1}), int'(expect_vec(1)));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int r_lat0, r_lat1, r_load, r_ren, r_last, r_nv, r_ren1, r_idx_stall, r_ren_stall, r_busy_evt;
  logic [5:0] r_rc_last, r_rc_stall, r_rc_first, r_rc1_last;
  bit r_rst_clean;

  // one encryption started at cycle 0; cycle c is the c-th cycle after start is sampled
  task automatic run_job(input int stall_c, input int stall_n, input int abort_c,
                         input int rst_c, input int bp_n);
    r_lat0 = -1; r_lat1 = -1; r_load = 0; r_ren = 0; r_last = 0; r_nv = 0; r_ren1 = 0;
    r_idx_stall = -1; r_ren_stall = 0; r_busy_evt = -1; r_rst_clean = 1'b0;
    r_rc_last = 6'h00; r_rc_stall = 6'h00; r_rc_first = 6'h00; r_rc1_last = 6'h00;
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      reset = (c != rst_c);
      abort = (c == abort_c) || (c == rst_c);
      stall = (c >= stall_c && c < stall_c + stall_n) || (c == rst_c);
      ready = (r_nv >= bp_n);
      start = (r_nv > 0) && (r_nv <= bp_n);
      #2;
      if (load0) r_load++;
      if (ren0) r_ren++;
      if (last0) begin r_last++; r_rc_last = rc0; end
      if (valid0) begin r_nv++; if (r_lat0 < 0) r_lat0 = c; end
      if (valid1 && r_lat1 < 0) r_lat1 = c;
      if (ren1) begin r_ren1++; r_rc1_last = rc1; end
      if (c == 2) r_rc_first = rc0;
      if (stall_n > 0 && c >= stall_c && c < stall_c + stall_n && ren0) r_ren_stall++;
      if (stall_n > 0 && c == stall_c + stall_n - 1) begin r_rc_stall = rc0; r_idx_stall = int'(idx0); end
      if (c == abort_c + 1 || c == rst_c + 1) begin
        r_busy_evt  = int'(busy0);
        r_rst_clean = ({busy0, load0, ren0, idx0, rc0, last0, valid0} == {3'b000, 6'd0, 6'h01, 2'b00});
      end
      tick();
    end
    reset = 1'b1; abort = 1'b0; stall = 1'b0; start = 1'b0; ready = 1'b1;
  endtask

  initial begin
    logic [5:0] v;
    v = 6'h01;
    for (int i = 0; i < 64; i++) begin
      rc_tab[i] = v;
      v = {v[4:0], v[5] ^ v[4] ^ 1'b1};
    end
    check("model rc idx5", int'(rc_tab[5]), 32'h3E);
    check("model rc idx11", int'(rc_tab[11]), 32'h3C);
    check("model rc idx55", int'(rc_tab[55]), 32'h0A);

    reset = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    check("reset state", int'({busy0, load0, ren0, idx0, rc0, last0, valid0}), int'({3'b000, 6'd0, 6'h01, 2'b00}));
    reset = 1'b1;
    tick();

    run_job(0, 0, 0, 0, 0);
    check("plain latency", r_lat0, 58);
    check("plain load count", r_load, 1);
    check("plain round_en count", r_ren, 56);
    check("plain last_round count", r_last, 1);
    check("plain rc at last", int'(r_rc_last), 32'h0A);
    check("plain valid cycles", r_nv, 1);
    check("n1 latency", r_lat1, 3);
    check("n1 round_en count", r_ren1, 1);
    check("n1 rc", int'(r_rc1_last), 32'h01);
    check("plain busy after", int'(busy0), 0);

    run_job(12, 3, 0, 0, 0);
    check("stall latency", r_lat0, 61);
    check("stall round_en during stall", r_ren_stall, 0);
    check("stall idx frozen", r_idx_stall, 10);
    check("stall rc frozen", int'(r_rc_stall), 32'h1E);
    check("stall round_en count", r_ren, 56);

    run_job(0, 0, 0, 0, 20);
    check("bp latency", r_lat0, 58);
    check("bp valid cycles", r_nv, 21);
    check("bp load count", r_load, 1);
    check("bp busy after", int'(busy0), 0);

    run_job(0, 0, 32, 0, 0);
    check("abort busy next", r_busy_evt, 0);
    check("abort no valid", r_nv, 0);

    run_job(0, 0, 0, 0, 0);
    check("post-abort latency", r_lat0, 58);
    check("post-abort rc first", int'(r_rc_first), 32'h01);

    run_job(0, 0, 0, 22, 0);
    check("reset mid-run clean", int'(r_rst_clean), 1);
    check("reset mid-run no valid", r_nv, 0);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(199) != 0);
      abort = ($urandom_range(63) == 0);
      stall = ($urandom_range(3) == 0);
      ready = ($urandom_range(2) != 0);
      start = ($urandom_range(7) == 0);
      tick();
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
